// File: rtl/regdump_pkg.sv
// ============================================================================
//  regdump_pkg
//  Shared types and constants for the register-file dump reader.
//  Build option: REGDUMP_SKIP_X0_EN (dump starts at x1 instead of x0).
//  Revision: 1.0
// ============================================================================
`default_nettype none

package regdump_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_e;

`ifdef REGDUMP_SKIP_X0_EN
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

    function automatic int max_idx(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_dump_reader.sv
// ============================================================================
//  regfile_dump_reader
//  Walks every GPR through a spare register-file read port and streams
//  (index, data) beats over valid/ready. Build option: REGDUMP_SKIP_X0_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] c_first_ptr = ADDR_WIDTH'(FIRST_IDX);
    localparam logic [ADDR_WIDTH-1:0] c_max_ptr   = ADDR_WIDTH'(max_idx(ADDR_WIDTH));

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,    rd_ptr_d;
    logic                    busy_q,      busy_d;
    logic                    out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]   out_idx_q,   out_idx_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    out_last_q,  out_last_d;
    logic                    done_q,      done_d;

    logic                    w_handshake;
    logic                    w_capture;

    assign w_handshake = out_valid_q && out_ready;
    // A beat is captured on entry to the stream and on every non-final handshake.
    assign w_capture   = (state_q == LOAD) ||
                         ((state_q == STREAM) && w_handshake && !out_last_q);

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (w_capture) begin
            out_data_d  = rf_rdata;
            out_idx_d   = rd_ptr_q;
            out_last_d  = (rd_ptr_q == c_max_ptr);
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_ptr_d = c_first_ptr;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (w_handshake && out_last_q) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    rd_ptr_d    = c_first_ptr;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= c_first_ptr;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rf_raddr  = rd_ptr_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

`default_nettype wire
